// File: rtl/systolic_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : systolic_ctrl                                                 |
// | Purpose  : Job sequencer for a weight-stationary ROWS x COLS systolic     |
// |            PE array. A job first strobes each row's weights into the     |
// |            array (LOAD), then streams k_len input vectors with a         |
// |            one-cycle-per-row skew and flags the cycles on which the      |
// |            final adder holds a valid result (STREAM), then pulses done.  |
// | Ports    : clk        - clock, rising edge                               |
// |            rstn       - asynchronous active-low reset                    |
// |            start      - one-cycle job request, honoured only when idle   |
// |            k_len      - number of input vectors, captured with start     |
// |            busy       - high while a job is in progress                  |
// |            done       - one-cycle completion pulse                       |
// |            preclk     - weight-latch strobe to the PE array              |
// |            w_row      - row addressed by the current preclk              |
// |            in_en      - per-row input-valid, row r lags row 0 by r       |
// |            t_cnt      - stream-phase cycle counter (low 8 bits)          |
// |            out_valid  - final adder output is valid                      |
// | Notes    : ROWS must be at least 2 so that w_row has a nonzero width.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module systolic_ctrl #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int LAT  = ROWS + COLS
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [7:0]              k_len,
  output logic                    busy,
  output logic                    done,
  output logic                    preclk,
  output logic [$clog2(ROWS)-1:0] w_row,
  output logic [ROWS-1:0]         in_en,
  output logic [7:0]              t_cnt,
  output logic                    out_valid
);

  localparam int WRW = $clog2(ROWS);
  // Stream counter is 10 bits; comparisons are done one bit wider so that
  // LAT + k_len and the wrap-around subtractions below never alias.
  localparam int CW  = 10;
  localparam int EW  = CW + 1;

  localparam logic [WRW-1:0] LAST_ROW = WRW'(ROWS - 1);
  localparam logic [EW-1:0]  LAT_E    = EW'(LAT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]     state,    state_nx;
  logic [7:0]     k_reg,    k_nx;
  logic [CW-1:0]  cnt,      cnt_nx;
  logic [WRW-1:0] wrow_reg, wrow_nx;
  logic           done_reg, done_nx;

  logic [EW-1:0]  cnt_ext;
  logic [EW-1:0]  k_ext;
  logic [EW-1:0]  last_t;
  logic           is_stream;

  assign cnt_ext   = {1'b0, cnt};
  assign k_ext     = {{(EW-8){1'b0}}, k_reg};
  // Final stream cycle: the one on which the last valid result is presented.
  assign last_t    = LAT_E + k_ext - EW'(1);
  assign is_stream = (state == S_STREAM);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    k_nx     = k_reg;
    cnt_nx   = cnt;
    wrow_nx  = wrow_reg;
    done_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (k_len != 8'd0) begin
            k_nx     = k_len;
            cnt_nx   = '0;
            wrow_nx  = '0;
            state_nx = S_LOAD;
          end else begin
            // Empty job: nothing to load or stream, just acknowledge it.
            done_nx = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (wrow_reg == LAST_ROW) begin
          // w_row is left at the last row; it only moves again in LOAD.
          cnt_nx   = '0;
          state_nx = S_STREAM;
        end else begin
          wrow_nx = wrow_reg + WRW'(1);
        end
      end
      S_STREAM: begin
        if (cnt_ext == last_t) begin
          // Counter is held so t_cnt keeps showing the final stream cycle.
          done_nx  = 1'b1;
          state_nx = S_DONE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      k_reg    <= 8'd0;
      cnt      <= '0;
      wrow_reg <= '0;
      done_reg <= 1'b0;
    end else begin
      state    <= state_nx;
      k_reg    <= k_nx;
      cnt      <= cnt_nx;
      wrow_reg <= wrow_nx;
      done_reg <= done_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode, purely from registered state and counter
  // --------------------------------------------------------------------------
  assign busy   = (state != S_IDLE);
  assign preclk = (state == S_LOAD);
  assign done   = done_reg;
  assign w_row  = wrow_reg;
  assign t_cnt  = cnt[7:0];

  // Window test r <= cnt < k+r is written as (cnt - r) < k: when cnt < r the
  // subtraction wraps to a value far above any 8-bit k, so one unsigned
  // compare covers both bounds.
  generate
    for (genvar r = 0; r < ROWS; r++) begin : g_in_en
      localparam logic [EW-1:0] R_OFS = EW'(r);
      assign in_en[r] = is_stream && ((cnt_ext - R_OFS) < k_ext);
    end
  endgenerate

  assign out_valid = is_stream && ((cnt_ext - LAT_E) < k_ext);

endmodule
`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_systolic_ctrl                                              |
// | Purpose  : Self-checking bench for systolic_ctrl with a job-level        |
// |            timing model and a behavioural PE array / dot-product check.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_systolic_ctrl;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int LAT  = ROWS + COLS;
  localparam int WRW  = $clog2(ROWS);

  logic            clk   = 1'b0;
  logic            rstn  = 1'b0;
  logic            start = 1'b0;
  logic [7:0]      k_len = 8'd0;
  logic            busy, done, preclk, out_valid;
  logic [WRW-1:0]  w_row;
  logic [ROWS-1:0] in_en;
  logic [7:0]      t_cnt;

  systolic_ctrl #(.ROWS(ROWS), .COLS(COLS), .LAT(LAT)) dut (
    .clk(clk), .rstn(rstn), .start(start), .k_len(k_len),
    .busy(busy), .done(done), .preclk(preclk), .w_row(w_row),
    .in_en(in_en), .t_cnt(t_cnt), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, want);
    end
  endtask

  // ---------------- job-level reference model ----------------
  // A job is described by the number of cycles elapsed since it was accepted:
  // cycles 1..ROWS load weights, the next LAT+k cycles stream, then one done.
  bit             m_act, m_pend0;
  int             m_e, m_k;
  logic [WRW-1:0] m_wrow;
  logic [7:0]     m_t;

  task automatic model_reset();
    m_act = 0; m_pend0 = 0; m_e = 0; m_k = 0; m_wrow = '0; m_t = 8'd0;
  endtask

  task automatic model_step(input bit s, input int kl);
    if (!m_act) begin
      m_pend0 = 0;
      if (s) begin
        if (kl != 0) begin
          m_act = 1; m_e = 1; m_k = kl; m_wrow = '0; m_t = 8'd0;
        end else begin
          m_pend0 = 1;
        end
      end
    end else begin
      m_e++;
      if (m_e > ROWS + LAT + m_k + 1) m_act = 0;
    end
  endtask

  // ---------------- behavioural PE array ----------------
  int W  [ROWS][COLS];
  int WL [ROWS][COLS];
  int X  [256][ROWS];
  int acc  [256];
  int nfed [256];

  task automatic randomize_data();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) W[r][c] = int'($urandom_range(0, 255));
    for (int j = 0; j < 256; j++)
      for (int r = 0; r < ROWS; r++) X[j][r] = int'($urandom_range(0, 255));
  endtask

  // ---------------- per-job statistics ----------------
  int n_busy, n_done, n_pre, n_ov, n_inen;
  int ov_first, ov_last, in0_first, in0_last, in3_first, in3_last, done_t;
  logic [31:0] wseq;

  task automatic clear_stats();
    n_busy = 0; n_done = 0; n_pre = 0; n_ov = 0; n_inen = 0;
    ov_first = -1; ov_last = -1; in0_first = -1; in0_last = -1;
    in3_first = -1; in3_last = -1; done_t = -1; wseq = 32'd0;
  endtask

  // One clock cycle: drive inputs, step DUT and model, compare everything.
  task automatic cyc(input bit s, input logic [7:0] kl);
    logic [17:0]     got, want;
    logic [ROWS-1:0] e_in;
    logic [7:0]      jb;
    bit              stream, e_pre, e_done, e_ov;
    int              t, j, refv;
    start = s;
    k_len = kl;
    @(posedge clk);
    #1;
    model_step(s, int'(kl));
    e_pre  = m_act && (m_e <= ROWS);
    if (e_pre) m_wrow = WRW'(m_e - 1);
    stream = m_act && (m_e > ROWS) && (m_e <= ROWS + LAT + m_k);
    t      = m_e - ROWS - 1;
    if (stream) m_t = t[7:0];
    e_done = m_pend0 || (m_act && (m_e == ROWS + LAT + m_k + 1));
    for (int r = 0; r < ROWS; r++) e_in[r] = stream && (t >= r) && (t < m_k + r);
    e_ov = stream && (t >= LAT) && (t < LAT + m_k);
    got  = {busy, done, preclk, w_row, in_en, t_cnt, out_valid};
    want = {m_act, e_done, e_pre, m_wrow, e_in, m_t, e_ov};
    check("cycle_outputs", 32'(got), 32'(want));

    n_busy += int'(busy); n_done += int'(done); n_pre += int'(preclk);
    n_ov += int'(out_valid); n_inen += $countones(in_en);
    if (preclk) wseq = (wseq << 4) | 32'(w_row);
    if (out_valid) begin if (ov_first < 0) ov_first = int'(t_cnt); ov_last = int'(t_cnt); end
    if (in_en[0]) begin if (in0_first < 0) in0_first = int'(t_cnt); in0_last = int'(t_cnt); end
    if (in_en[ROWS-1]) begin if (in3_first < 0) in3_first = int'(t_cnt); in3_last = int'(t_cnt); end
    if (done) done_t = int'(t_cnt);

    // Array side: latch weights on preclk, accumulate row products on in_en,
    // and compare the adder result with a direct dot product on out_valid.
    if (preclk) begin
      if (w_row == '0)
        for (int q = 0; q < 256; q++) begin acc[q] = 0; nfed[q] = 0; end
      for (int c = 0; c < COLS; c++) WL[w_row][c] = W[w_row][c];
    end
    for (int r = 0; r < ROWS; r++) begin
      if (in_en[r]) begin
        jb = t_cnt - 8'(r);
        j  = int'(jb);
        for (int c = 0; c < COLS; c++) acc[j] += WL[r][c] * X[j][r];
        nfed[j]++;
      end
    end
    if (out_valid) begin
      jb = t_cnt - 8'(LAT);
      j  = int'(jb);
      refv = 0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) refv += W[r][c] * X[j][r];
      check("dot_product", 32'(acc[j]), 32'(refv));
      check("rows_fed", 32'(nfed[j]), 32'(ROWS));
    end
  endtask

  task automatic run_job(input int k, input int poke);
    clear_stats();
    cyc(1'b1, 8'(k));
    for (int i = 1; i <= ROWS + LAT + k + 2; i++)
      cyc(i == poke, 8'($urandom_range(1, 255)));
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({busy, done, preclk, w_row, in_en, t_cnt, out_valid}), 32'd0);
  endtask

  typedef struct {
    int k;
    int busy_c;
    int ov_c;
    int inen_c;
    int pre_c;
    int done_c;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1,   14,  1,   4,    4, 1};
    tbl[1] = '{0,   0,   0,   0,    0, 1};
    tbl[2] = '{7,   20,  7,   28,   4, 1};
    tbl[3] = '{20,  33,  20,  80,   4, 1};
    tbl[4] = '{255, 268, 255, 1020, 4, 1};

    model_reset();
    clear_stats();
    randomize_data();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rstn = 1'b1;

    // Basic k_len=3 job with explicit timing points
    run_job(3, 0);
    check("k3_wrow_seq", wseq, 32'h0123);
    check("k3_preclk", 32'(n_pre), 32'd4);
    check("k3_in0_first", 32'(in0_first), 32'd0);
    check("k3_in0_last", 32'(in0_last), 32'd2);
    check("k3_in3_first", 32'(in3_first), 32'd3);
    check("k3_in3_last", 32'(in3_last), 32'd5);
    check("k3_ov_first", 32'(ov_first), 32'd8);
    check("k3_ov_last", 32'(ov_last), 32'd10);
    check("k3_done_cnt", 32'(n_done), 32'd1);
    check("k3_done_tcnt", 32'(done_t), 32'd10);

    // Table of job lengths with whole-job totals
    for (int i = 0; i < 5; i++) begin
      randomize_data();
      run_job(tbl[i].k, 0);
      check("tbl_busy", 32'(n_busy), 32'(tbl[i].busy_c));
      check("tbl_ov", 32'(n_ov), 32'(tbl[i].ov_c));
      check("tbl_inen", 32'(n_inen), 32'(tbl[i].inen_c));
      check("tbl_preclk", 32'(n_pre), 32'(tbl[i].pre_c));
      check("tbl_done", 32'(n_done), 32'(tbl[i].done_c));
    end
    // Last table entry was k=255: t_cnt must wrap (LAT+254 = 262 -> 6)
    check("k255_ov_first", 32'(ov_first), 32'd8);
    check("k255_ov_last", 32'(ov_last), 32'd6);

    // Restart attempt in the middle of STREAM is ignored
    run_job(5, ROWS + 3);
    check("restart_busy", 32'(n_busy), 32'd18);
    check("restart_ov", 32'(n_ov), 32'd5);
    check("restart_done", 32'(n_done), 32'd1);

    // Asynchronous reset at t_cnt=5 of a k_len=20 job
    clear_stats();
    cyc(1'b1, 8'd20);
    for (int i = 0; i < ROWS + 5; i++) cyc(1'b0, 8'd9);
    check("abort_point_tcnt", 32'(t_cnt), 32'd5);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_all_zero("held_reset");
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    rstn = 1'b1;
    run_job(20, 0);
    check("after_abort_done", 32'(n_done), 32'd1);
    check("after_abort_ov", 32'(n_ov), 32'd20);

    // Randomized traffic: random start pulses and lengths, some zero-length
    randomize_data();
    clear_stats();
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 7) == 0),
          ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 40)));
    end
    for (int i = 0; i < ROWS + LAT + 45; i++) cyc(1'b0, 8'd0);
    check("random_end_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 4, the number of PE rows (weight and input lanes).
REQ-002 SHALL have parameter COLS, default 4, the number of PE columns.
REQ-003 SHALL have parameter LAT, default ROWS+COLS, the cycles from the first row-0 input to the first valid final psum.
REQ-004 SHALL have port clk  input  1  the only clock; all state changes on the rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  input  1  one-cycle job request, sampled only in IDLE.
REQ-007 SHALL have port k_len  input  8  number of input vectors in the job, captured with start.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse at job completion.
REQ-010 SHALL have port preclk  output  1  weight-latch strobe to the PE array.
REQ-011 SHALL have port w_row  output  $clog2(ROWS)  row whose weights are on the weight bus during preclk.
REQ-012 SHALL have port in_en  output  ROWS  per-row input-valid, skewed one cycle per row.
REQ-013 SHALL have port t_cnt  output  8  stream-phase cycle counter; row r uses vector index t_cnt-r.
REQ-014 SHALL have port out_valid  output  1  high while the final adder output holds a valid result.

Function
REQ-015 SHALL implement states IDLE, LOAD, STREAM, DONE.
REQ-016 SHALL, in IDLE with start=1 and k_len>0, capture k_len, clear w_row and t_cnt, and enter LOAD next cycle.
REQ-017 SHALL, in IDLE with start=1 and k_len=0, stay in IDLE, assert done for the next cycle only, and never assert preclk, in_en or out_valid.
REQ-018 SHALL, in LOAD, assert preclk for exactly one cycle per row, with w_row=0..ROWS-1 in consecutive cycles (ROWS cycles total).
REQ-019 SHALL enter STREAM on the cycle after the preclk with w_row=ROWS-1, with t_cnt=0.
REQ-020 SHALL, in STREAM, increment t_cnt by 1 every cycle.
REQ-021 SHALL drive in_en[r]=1 exactly when busy is high in STREAM and r <= t_cnt < k_len+r.
REQ-022 SHALL drive out_valid=1 exactly when in STREAM and LAT <= t_cnt < LAT+k_len.
REQ-023 SHALL leave STREAM for DONE when t_cnt = LAT+k_len-1; DONE asserts done for one cycle, then returns to IDLE.
REQ-024 SHALL size the internal stream counter at 10 bits so LAT+k_len up to 255+LAT does not wrap; t_cnt is its low 8 bits.
REQ-025 SHALL ignore start in every state other than IDLE; a running job is not restarted or extended.
REQ-026 SHALL ignore changes on k_len after capture.
REQ-027 SHALL register all outputs; in_en and out_valid are decoded from registered state and counter, with no combinational path from start.
REQ-028 SHALL hold w_row at its last value outside LOAD.

Reset
REQ-029 SHALL, on rstn=0, force IDLE immediately regardless of state and zero busy, done, preclk, w_row, in_en, t_cnt and out_valid.
REQ-030 SHALL, on rstn=0 during LOAD or STREAM, abandon the job with no done pulse; the next job begins only on a new start after rstn=1.

Verification
REQ-031 SHALL be checked with this stimulus: ROWS=4, COLS=4, start with k_len=3. Required response: preclk high 4 cycles with w_row 0,1,2,3; in_en[0] at t_cnt 0-2; in_en[3] at t_cnt 3-5; out_valid at t_cnt 8-10; done 1 cycle after t_cnt=10.
REQ-032 SHALL be checked with this stimulus: start with k_len=0. Required response: done one cycle later; busy, preclk, in_en and out_valid stay 0.
REQ-033 SHALL be checked with this stimulus: start pulsed again mid-STREAM with a different k_len. Required response: no effect on timing; a single done.
REQ-034 SHALL be checked with this stimulus: rstn low at t_cnt=5 during a k_len=20 job. Required response: all outputs 0 asynchronously, no done; a new start after release runs a complete job.
REQ-035 SHALL be checked with this stimulus: k_len=255. Required response: out_valid high for exactly 255 cycles; t_cnt wraps while the internal counter does not; done issued once.
REQ-036 SHALL be checked with this stimulus: integration against the 4x4 PE array and final adder, with random weights and inputs. Required response: each out_valid cycle matches a reference dot-product model.
